thd_meas_ctrl: RTL

Measurement sequencer for the THD analysis chain. It owns the sample-rate select for the ADC clock mux, starts each capture and each FFT pass, and waits for their completion under a timeout. It checks the fundamental bin index and auto-ranges the sample rate (1 MHz / 640 kHz / 256 kHz) until the fundamental lands in a usable band, then latches the THD result for the display path. It sits between the key/debounce logic and the ADC capture/FFT datapath, all in the 50 MHz domain.

---
 rtl/thd_meas_ctrl_if.sv | 30 +++
 rtl/thd_meas_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/thd_meas_ctrl_if.sv
// Capture/FFT handshake between the THD measurement sequencer (master)
// and the ADC capture / FFT datapath (slave).
interface thd_meas_ctrl_if;
  localparam int unsigned DATA_W = 16;

  logic              cap_start;
  logic              cap_done;
  logic              fft_start;
  logic              res_valid;
  logic [DATA_W-1:0] max_index;
  logic [DATA_W-1:0] thd_in;

  modport master (
    output cap_start,
    output fft_start,
    input  cap_done,
    input  res_valid,
    input  max_index,
    input  thd_in
  );

  modport slave (
    input  cap_start,
    input  fft_start,
    output cap_done,
    output res_valid,
    output max_index,
    output thd_in
  );
endinterface

// File: rtl/thd_meas_ctrl.sv
// THD measurement sequencer: capture -> FFT -> bin check, with timeouts and result latch.
// THD_AUTORANGE_EN enables sample-rate auto-ranging; otherwise the rate comes from manual_rate.
module thd_meas_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 50_000_000,
  parameter int unsigned SETTLE_CYC  = 1024,
  parameter int unsigned BIN_LO      = 32,
  parameter int unsigned BIN_HI      = 400,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            start,
  input  logic            auto_mode,
  input  logic [1:0]      manual_rate,
  output logic [1:0]      rate_sel,
  thd_meas_ctrl_if.master dp,
  output logic [15:0]     thd_out,
  output logic [1:0]      rate_out,
  output logic            busy,
  output logic            done,
  output logic [1:0]      err
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned SET_W  = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam int unsigned RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_RETRY   = 2'b11;

  typedef enum logic [2:0] {
    IDLE, SETTLE, CAPTURE, WAIT_CAP, FFT, WAIT_FFT, CHECK, DONE
  } state_t;

  state_t            state, state_nxt;
  logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
  logic [SET_W-1:0]  set_cnt, set_cnt_nxt;
  logic [RTY_W-1:0]  retry_cnt, retry_nxt;
  logic [DATA_W-1:0] idx_q, idx_nxt;
  logic [DATA_W-1:0] thd_q, thd_q_nxt;
  logic [DATA_W-1:0] thd_out_nxt;
  logic [1:0]        rate_sel_nxt, rate_out_nxt, err_nxt;
  logic [1:0]        want_rate, start_rate, chk_err;
  logic              chk_rerange, to_hit, set_hit;
  logic              unused_ok;

  assign to_hit  = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign set_hit = (set_cnt == SET_W'(SETTLE_CYC));

`ifdef THD_AUTORANGE_EN
  localparam state_t START_ST = CAPTURE;

  logic idx_high, idx_low, want_ok;

  // Bin check: too high a bin wants a faster rate (lower code), too low a slower one.
  always_comb begin
    idx_high    = (idx_q > DATA_W'(BIN_HI));
    idx_low     = (idx_q < DATA_W'(BIN_LO));
    want_rate   = rate_sel;
    want_ok     = 1'b1;
    chk_rerange = 1'b0;
    chk_err     = ERR_OK;
    if (idx_high) begin
      want_ok   = (rate_sel != 2'd0);
      want_rate = rate_sel - 2'd1;
    end else if (idx_low) begin
      want_ok   = (rate_sel < 2'd2);
      want_rate = rate_sel + 2'd1;
    end
    if (idx_high || idx_low) begin
      if (!want_ok)                               chk_err = ERR_RANGE;
      else if (retry_cnt == RTY_W'(MAX_RETRY))    chk_err = ERR_RETRY;
      else                                        chk_rerange = 1'b1;
    end
  end

  assign start_rate = rate_sel;
  assign unused_ok  = ^manual_rate;
`else
  localparam state_t START_ST = SETTLE;

  assign chk_rerange = 1'b0;
  assign chk_err     = ERR_OK;
  assign want_rate   = rate_sel;
  // Code 3 is not a valid mux setting; clamp to the slowest rate.
  assign start_rate  = (manual_rate == 2'd3) ? 2'd2 : manual_rate;
  assign unused_ok   = ^{idx_q, retry_cnt, DATA_W'(BIN_LO), DATA_W'(BIN_HI), RTY_W'(MAX_RETRY)};
`endif

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = START_ST;
      SETTLE:   if (set_hit) state_nxt = CAPTURE;
      CAPTURE:  state_nxt = WAIT_CAP;
      WAIT_CAP: begin
        if (dp.cap_done)  state_nxt = FFT;
        else if (to_hit)  state_nxt = DONE;
      end
      FFT:      state_nxt = WAIT_FFT;
      WAIT_FFT: begin
        if (dp.res_valid) state_nxt = CHECK;
        else if (to_hit)  state_nxt = DONE;
      end
      CHECK:    state_nxt = chk_rerange ? SETTLE : DONE;
      DONE:     state_nxt = auto_mode ? CAPTURE : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Datapath/output next values; counters restart from zero whenever their state is left.
  always_comb begin
    rate_sel_nxt = rate_sel;
    rate_out_nxt = rate_out;
    thd_out_nxt  = thd_out;
    err_nxt      = err;
    retry_nxt    = retry_cnt;
    idx_nxt      = idx_q;
    thd_q_nxt    = thd_q;
    to_cnt_nxt   = '0;
    set_cnt_nxt  = '0;
    case (state)
      IDLE: begin
        if (start) begin
          err_nxt      = ERR_OK;
          retry_nxt    = '0;
          rate_sel_nxt = start_rate;
        end
      end
      SETTLE: begin
        if (!set_hit) set_cnt_nxt = set_cnt + SET_W'(1);
      end
      WAIT_CAP: begin
        if (!dp.cap_done) begin
          if (to_hit) err_nxt    = ERR_TIMEOUT;
          else        to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      WAIT_FFT: begin
        if (dp.res_valid) begin
          idx_nxt   = dp.max_index;
          thd_q_nxt = dp.thd_in;
        end else if (to_hit) begin
          err_nxt = ERR_TIMEOUT;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      CHECK: begin
        if (chk_rerange) begin
          rate_sel_nxt = want_rate;
          retry_nxt    = retry_cnt + RTY_W'(1);
        end else begin
          err_nxt      = chk_err;
          thd_out_nxt  = thd_q;
          rate_out_nxt = rate_sel;
        end
      end
      DONE: begin
        if (auto_mode) begin
          err_nxt   = ERR_OK;
          retry_nxt = '0;
        end
      end
      default: ;
    endcase
  end

  // State and registered outputs; strobes are decoded from the next state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      to_cnt       <= '0;
      set_cnt      <= '0;
      retry_cnt    <= '0;
      idx_q        <= '0;
      thd_q        <= '0;
      rate_sel     <= 2'd0;
      rate_out     <= 2'd0;
      thd_out      <= '0;
      err          <= ERR_OK;
      busy         <= 1'b0;
      done         <= 1'b0;
      dp.cap_start <= 1'b0;
      dp.fft_start <= 1'b0;
    end else begin
      state        <= state_nxt;
      to_cnt       <= to_cnt_nxt;
      set_cnt      <= set_cnt_nxt;
      retry_cnt    <= retry_nxt;
      idx_q        <= idx_nxt;
      thd_q        <= thd_q_nxt;
      rate_sel     <= rate_sel_nxt;
      rate_out     <= rate_out_nxt;
      thd_out      <= thd_out_nxt;
      err          <= err_nxt;
      busy         <= (state_nxt != IDLE);
      done         <= (state_nxt == DONE);
      dp.cap_start <= (state_nxt == CAPTURE);
      dp.fft_start <= (state_nxt == FFT);
    end
  end

endmodule
